// File: rtl/matrix_calculator_core_pkg.sv
// matrix_calculator_core_pkg: opcodes, FSM states and default widths for the matrix engine.
// Rev 1.0
`default_nettype none
package matrix_calculator_core_pkg;
  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 8;
  localparam int DIMW_DEF = 3;

  localparam logic [2:0] OP_TRANSPOSE = 3'd0;
  localparam logic [2:0] OP_ADD       = 3'd1;
  localparam logic [2:0] OP_SCALAR    = 3'd2;
  localparam logic [2:0] OP_MATMUL    = 3'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RD_S, S_WAIT_S, S_LD_S, S_RD_A,
    S_WAIT_A, S_RD_B, S_WAIT_B, S_ACC, S_WR, S_DONE
  } calc_state_t;
endpackage
`default_nettype wire

// File: rtl/matrix_calculator_core_mac.sv
// matrix_calc_mac: signed multiply-accumulate, wrapping to DW bits, with synchronous clear.
// Rev 1.0
`default_nettype none
module matrix_calc_mac
  import matrix_calculator_core_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc
);
  logic [DW-1:0] prod;

  assign prod = $signed(a) * $signed(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + prod;
  end
endmodule
`default_nettype wire

// File: rtl/matrix_calculator_core.sv
// matrix_calculator_core: reads operand matrices from shared storage, computes add / scalar-mul /
// transpose / matmul per element and writes the result back row-major. Rev 1.0
`default_nettype none
module matrix_calculator_core
  import matrix_calculator_core_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int DIMW = DIMW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start_calc,
  input  logic [2:0]      i_op_code,
  input  logic [AW-1:0]   i_op1_addr,
  input  logic [DIMW-1:0] i_op1_m,
  input  logic [DIMW-1:0] i_op1_n,
  input  logic [AW-1:0]   i_op2_addr,
  input  logic [DIMW-1:0] i_op2_m,
  input  logic [DIMW-1:0] i_op2_n,
  input  logic [AW-1:0]   i_res_addr,
  input  logic [DW-1:0]   i_storage_rdata,
  output logic [AW-1:0]   o_calc_req_addr,
  output logic [AW-1:0]   o_calc_waddr,
  output logic [DW-1:0]   o_calc_wdata,
  output logic            o_calc_we,
  output logic            o_calc_done,
  output logic            o_calc_err,
  output logic [DIMW-1:0] o_res_m,
  output logic [DIMW-1:0] o_res_n
);
  calc_state_t     state;
  logic [2:0]      op;
  logic [AW-1:0]   a_base, b_base, r_base;
  logic [DIMW-1:0] a_m, a_n, b_m, b_n;
  logic [DIMW-1:0] i, j, k;
  logic [DW-1:0]   a_val, scalar, sum, acc, mac_a;
  logic [DIMW-1:0] a_row, a_col, b_row, b_col, rm, rn;
  logic [AW-1:0]   a_addr, b_addr, w_addr;
  logic            legal, mac_clr, mac_en;

  function automatic logic [AW-1:0] elem_addr(input logic [AW-1:0] base, input logic [DIMW-1:0] row,
                                              input logic [DIMW-1:0] ncols, input logic [DIMW-1:0] col);
    logic [2*DIMW-1:0] off;
    off = {{DIMW{1'b0}}, row} * {{DIMW{1'b0}}, ncols};
    return base + AW'(off) + AW'(col);
  endfunction

  always_comb begin
    a_row = i; a_col = j; b_row = i; b_col = j;
    case (op)
      OP_TRANSPOSE: begin a_row = j; a_col = i; end
      OP_MATMUL:    begin a_col = k; b_row = k; end
      default: ;
    endcase
  end

  assign a_addr = elem_addr(a_base, a_row, a_n, a_col);
  assign b_addr = elem_addr(b_base, b_row, b_n, b_col);
  assign w_addr = elem_addr(r_base, i, o_res_n, j);

  always_comb begin
    legal = (a_m != '0) && (a_n != '0);
    rm = a_m;
    rn = a_n;
    case (op)
      OP_TRANSPOSE: begin rm = a_n; rn = a_m; end
      OP_ADD:       if (b_m != a_m || b_n != a_n) legal = 1'b0;
      OP_SCALAR:    if (b_m != DIMW'(1) || b_n != DIMW'(1)) legal = 1'b0;
      OP_MATMUL:    begin rn = b_n; if (a_n != b_m || b_n == '0) legal = 1'b0; end
      default:      legal = 1'b0;
    endcase
  end

  // Transpose passes A through the MAC as 1*A so every non-add result comes from the accumulator.
  always_comb begin
    mac_a = a_val;
    if (op == OP_SCALAR)         mac_a = scalar;
    else if (op == OP_TRANSPOSE) mac_a = {{(DW-1){1'b0}}, 1'b1};
  end
  assign mac_clr = (state == S_CHECK) || (state == S_WR);
  assign mac_en  = (state == S_ACC) && (op != OP_ADD);

  matrix_calc_mac #(.DW(DW)) u_mac (
    .clk(clk), .rst_n(rst_n), .clr(mac_clr), .en(mac_en),
    .a(mac_a), .b(i_storage_rdata), .acc(acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; op <= '0;
      a_base <= '0; b_base <= '0; r_base <= '0;
      a_m <= '0; a_n <= '0; b_m <= '0; b_n <= '0;
      i <= '0; j <= '0; k <= '0;
      a_val <= '0; scalar <= '0; sum <= '0;
      o_calc_req_addr <= '0; o_calc_waddr <= '0; o_calc_wdata <= '0;
      o_calc_we <= 1'b0; o_calc_done <= 1'b0; o_calc_err <= 1'b0;
      o_res_m <= '0; o_res_n <= '0;
    end else begin
      o_calc_we <= 1'b0;
      if (state != S_IDLE && !i_start_calc) begin
        state <= S_IDLE;
        o_calc_done <= 1'b0; o_calc_err <= 1'b0;
        o_res_m <= '0; o_res_n <= '0;
      end else begin
        case (state)
          S_IDLE: if (i_start_calc) begin
            op <= i_op_code;
            a_base <= i_op1_addr; a_m <= i_op1_m; a_n <= i_op1_n;
            b_base <= i_op2_addr; b_m <= i_op2_m; b_n <= i_op2_n;
            r_base <= i_res_addr;
            state <= S_CHECK;
          end
          S_CHECK: begin
            i <= '0; j <= '0; k <= '0;
            if (legal) begin
              o_res_m <= rm; o_res_n <= rn;
              state <= (op == OP_SCALAR) ? S_RD_S : S_RD_A;
            end else begin
              o_calc_err <= 1'b1;
              state <= S_DONE;
            end
          end
          S_RD_S:   begin o_calc_req_addr <= b_base; state <= S_WAIT_S; end
          S_WAIT_S: state <= S_LD_S;
          S_LD_S:   begin scalar <= i_storage_rdata; state <= S_RD_A; end
          S_RD_A:   begin o_calc_req_addr <= a_addr; state <= S_WAIT_A; end
          S_WAIT_A: state <= (op == OP_TRANSPOSE || op == OP_SCALAR) ? S_ACC : S_RD_B;
          S_RD_B: begin
            a_val <= i_storage_rdata;
            o_calc_req_addr <= b_addr;
            state <= S_WAIT_B;
          end
          S_WAIT_B: state <= S_ACC;
          S_ACC: begin
            sum <= a_val + i_storage_rdata;
            if (op == OP_MATMUL && (k + DIMW'(1)) < a_n) begin
              k <= k + DIMW'(1);
              state <= S_RD_A;
            end else begin
              state <= S_WR;
            end
          end
          S_WR: begin
            o_calc_we <= 1'b1;
            o_calc_waddr <= w_addr;
            o_calc_wdata <= (op == OP_ADD) ? sum : acc;
            k <= '0;
            if ((j + DIMW'(1)) < o_res_n) begin
              j <= j + DIMW'(1);
              state <= S_RD_A;
            end else if ((i + DIMW'(1)) < o_res_m) begin
              i <= i + DIMW'(1);
              j <= '0;
              state <= S_RD_A;
            end else begin
              state <= S_DONE;
            end
          end
          S_DONE:  o_calc_done <= 1'b1;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_matrix_calculator_core.sv
// tb_matrix_calculator_core: directed stimulus with a write scoreboard fed by a reference model.
// Rev 1.0
`default_nettype none
module tb_matrix_calculator_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op_code = '0;
  logic [7:0]  op1_addr = '0, op2_addr = '0, res_addr = '0;
  logic [2:0]  op1_m = '0, op1_n = '0, op2_m = '0, op2_n = '0;
  logic [31:0] rdata = '0;
  logic [7:0]  req_addr, waddr;
  logic [31:0] wdata;
  logic        we, done, err;
  logic [2:0]  res_m, res_n;

  logic [31:0] mem [256];
  logic        ld_we = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  typedef struct {logic [7:0] addr; logic [31:0] data;} wr_t;
  wr_t exp_q[$];

  int total = 0, passed = 0, failed = 0, wr_count = 0;

  matrix_calculator_core dut (
    .clk(clk), .rst_n(rst_n), .i_start_calc(start), .i_op_code(op_code),
    .i_op1_addr(op1_addr), .i_op1_m(op1_m), .i_op1_n(op1_n),
    .i_op2_addr(op2_addr), .i_op2_m(op2_m), .i_op2_n(op2_n),
    .i_res_addr(res_addr), .i_storage_rdata(rdata),
    .o_calc_req_addr(req_addr), .o_calc_waddr(waddr), .o_calc_wdata(wdata),
    .o_calc_we(we), .o_calc_done(done), .o_calc_err(err),
    .o_res_m(res_m), .o_res_n(res_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (we) mem[waddr] <= wdata;
    rdata <= mem[req_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      wr_t e;
      wr_count++;
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_addr", 32'(waddr), 32'(e.addr));
        check("write_data", wdata, e.data);
      end
    end
  end

  task automatic poke(input int addr, input int data);
    ld_addr = 8'(addr); ld_data = data; ld_we = 1'b1;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic load(input int base, input int n, input int v[9]);
    for (int t = 0; t < n; t++) poke(base + t, v[t]);
  endtask

  function automatic int el(input int base, input int r, input int n, input int c);
    return mem[8'(base + r * n + c)];
  endfunction

  task automatic model(input int op, input int ab, input int am, input int an,
                       input int bb, input int bn, input int rb);
    int rm, rn, v;
    rm = am; rn = an;
    if (op == 0) begin rm = an; rn = am; end
    if (op == 3) rn = bn;
    for (int r = 0; r < rm; r++)
      for (int c = 0; c < rn; c++) begin
        case (op)
          0: v = el(ab, c, an, r);
          1: v = el(ab, r, an, c) + el(bb, r, bn, c);
          2: v = int'(mem[8'(bb)]) * el(ab, r, an, c);
          default: begin
            v = 0;
            for (int q = 0; q < an; q++) v += el(ab, r, an, q) * el(bb, q, bn, c);
          end
        endcase
        exp_q.push_back('{addr: 8'(rb + r * rn + c), data: v});
      end
  endtask

  task automatic set_op(input int op, input int ab, input int am, input int an,
                        input int bb, input int bm, input int bn, input int rb);
    op_code = 3'(op); op1_addr = 8'(ab); op1_m = 3'(am); op1_n = 3'(an);
    op2_addr = 8'(bb); op2_m = 3'(bm); op2_n = 3'(bn); res_addr = 8'(rb);
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin @(negedge clk); cyc++; end
  endtask

  task automatic run_op(input string tag, input int op, input int ab, input int am, input int an,
                        input int bb, input int bm, input int bn, input int rb,
                        input bit exp_err, input int erm, input int ern);
    int cyc, w0;
    set_op(op, ab, am, an, bb, bm, bn, rb);
    if (!exp_err) model(op, ab, am, an, bb, bn, rb);
    w0 = wr_count;
    start = 1'b1;
    wait_done(400, cyc);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    if (exp_err) begin
      check({tag, "_err_latency_le4"}, 32'(cyc <= 4), 32'd1);
      check({tag, "_no_writes"}, 32'(wr_count - w0), 32'd0);
    end else begin
      check({tag, "_res_m"}, 32'(res_m), 32'(erm));
      check({tag, "_res_n"}, 32'(res_n), 32'(ern));
      check({tag, "_all_writes"}, 32'(exp_q.size()), 32'd0);
    end
    repeat (2) @(negedge clk);
    check({tag, "_done_held"}, 32'(done), 32'd1);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_err_clr"}, 32'(err), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv[9];
    int w0, cyc;
    repeat (3) @(negedge clk);
    check("rst_req_addr", 32'(req_addr), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_res_m", 32'(res_m), 32'd0);
    check("rst_res_n", 32'(res_n), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Add
    load(0, 6, '{4, 5, 6, 7, 8, 9, 0, 0, 0});
    load(6, 6, '{1, 1, 1, 2, 2, 2, 0, 0, 0});
    run_op("add", 1, 0, 2, 3, 6, 2, 3, 40, 1'b0, 2, 3);
    rv = '{5, 6, 7, 9, 10, 11, 0, 0, 0};
    for (int t = 0; t < 6; t++) check("add_mem", mem[40 + t], rv[t]);

    // Matmul
    load(0, 6, '{1, 2, 3, 4, 5, 6, 0, 0, 0});
    load(12, 6, '{1, 0, 0, 1, 1, 1, 0, 0, 0});
    run_op("matmul", 3, 0, 2, 3, 12, 3, 2, 40, 1'b0, 2, 2);
    rv = '{4, 5, 10, 11, 0, 0, 0, 0, 0};
    for (int t = 0; t < 4; t++) check("matmul_mem", mem[40 + t], rv[t]);

    // Transpose
    load(0, 6, '{4, 5, 6, 7, 8, 9, 0, 0, 0});
    run_op("transpose", 0, 0, 2, 3, 0, 0, 0, 40, 1'b0, 3, 2);
    rv = '{4, 7, 5, 8, 6, 9, 0, 0, 0};
    for (int t = 0; t < 6; t++) check("transpose_mem", mem[40 + t], rv[t]);

    // Scalar multiply, including a wrapping product
    poke(20, -3);
    load(0, 4, '{1, -2, 3, 0, 0, 0, 0, 0, 0});
    run_op("scalar", 2, 0, 2, 2, 20, 1, 1, 40, 1'b0, 2, 2);
    rv = '{-3, 6, -9, 0, 0, 0, 0, 0, 0};
    for (int t = 0; t < 4; t++) check("scalar_mem", mem[40 + t], rv[t]);
    poke(20, 2);
    poke(0, 32'h7FFF_FFFF);
    run_op("scalar_wrap", 2, 0, 1, 1, 20, 1, 1, 50, 1'b0, 1, 1);
    check("scalar_wrap_mem", mem[50], 32'hFFFF_FFFE);

    // Random signed 3x3 matmul and an add whose result wraps past address 255
    for (int t = 0; t < 18; t++) poke(100 + t, int'($urandom_range(0, 200)) - 100);
    run_op("matmul3", 3, 100, 3, 3, 109, 3, 3, 60, 1'b0, 3, 3);
    run_op("add_wrap", 1, 100, 1, 3, 103, 1, 3, 254, 1'b0, 1, 3);

    // Illegal requests
    run_op("err_dims", 1, 0, 2, 3, 6, 2, 2, 40, 1'b1, 0, 0);
    run_op("err_opcode", 5, 0, 2, 2, 6, 2, 2, 40, 1'b1, 0, 0);
    run_op("err_zero", 0, 0, 0, 3, 0, 0, 0, 40, 1'b1, 0, 0);
    run_op("err_scalar", 2, 0, 2, 2, 20, 1, 2, 40, 1'b1, 0, 0);

    // Abort by dropping start mid-matmul
    set_op(3, 100, 3, 3, 109, 3, 3, 60);
    w0 = wr_count;
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_we", 32'(we), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (30) @(negedge clk);
    check("abort_no_writes", 32'(wr_count - w0), 32'd0);

    // Asynchronous reset mid-matmul
    start = 1'b1;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(we), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_req_addr", 32'(req_addr), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_no_writes", 32'(wr_count - w0), 32'd0);
    check("arst_idle_done", 32'(done), 32'd0);

    // Recovery after abort and reset
    run_op("matmul_again", 3, 0, 2, 3, 12, 3, 2, 70, 1'b0, 2, 2);

    // Done must stay low with start held low
    wait_done(5, cyc);
    check("idle_no_done", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
